// File: rtl/game_pkg.sv
// Shared definitions for the flappy-bird game blocks: game phases and default timing constants.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        PLAY = 2'd2,
        OVER = 2'd3
    } game_state_t;

    localparam int unsigned SCROLL_DIV_DEFAULT = 50_000_000;
    localparam int unsigned FALL_DIV_DEFAULT   = 25_000_000;
    localparam int unsigned HOLDOFF_DEFAULT    = 100_000_000;
    localparam int unsigned SCORE_W_DEFAULT    = 8;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: emits a 1-cycle tick the cycle after the count wraps from DIV-1 to 0.
module tick_gen #(
    parameter int unsigned DIV = 2
) (
    input  logic clock,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = $clog2(DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_count;

    // Count enabled cycles; clear restarts from zero and drops any pending tick.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_count <= '0;
            tick    <= 1'b0;
        end else if (enable) begin
            if (r_count == LAST) begin
                r_count <= '0;
                tick    <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
                tick    <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: IDLE -> ARM -> PLAY -> OVER, with tick generation, flap forwarding and scoring.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned SCROLL_DIV = SCROLL_DIV_DEFAULT,
    parameter int unsigned FALL_DIV   = FALL_DIV_DEFAULT,
    parameter int unsigned HOLDOFF    = HOLDOFF_DEFAULT,
    parameter int unsigned SCORE_W    = SCORE_W_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flap_btn,
    input  logic               pipe_pass,
    input  logic               lossDetect,
    output logic               clr_collide,
    output logic               scroll_tick,
    output logic               fall_tick,
    output logic               flap_pulse,
    output logic               playing,
    output logic               game_over,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] best_score
);

    localparam int unsigned HW = $clog2(HOLDOFF + 1);
    localparam logic [HW-1:0]      HOLDOFF_LAST = HW'(HOLDOFF);
    localparam logic [SCORE_W-1:0] SCORE_MAX    = '1;

    game_state_t        r_state;
    game_state_t        w_next_state;
    logic               r_flap_q;
    logic               w_flap_rise;
    logic               r_clr_collide;
    logic               r_flap_pulse;
    logic               r_playing;
    logic               r_game_over;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_best;
    logic [HW-1:0]      r_holdoff;

    logic               w_flap_pulse_next;
    logic [SCORE_W-1:0] w_score_next;
    logic [SCORE_W-1:0] w_best_next;
    logic [HW-1:0]      w_holdoff_next;
    logic               w_tick_clear;
    logic               w_tick_enable;

    assign w_flap_rise = flap_btn & ~r_flap_q;

    // Reset must also wipe the prescalers, which only have a clear input.
    assign w_tick_clear  = reset | (r_state == ARM);
    assign w_tick_enable = (r_state == PLAY) & ~lossDetect;

    tick_gen #(.DIV(SCROLL_DIV)) u_scroll (
        .clock  (clock),
        .clear  (w_tick_clear),
        .enable (w_tick_enable),
        .tick   (scroll_tick)
    );

    tick_gen #(.DIV(FALL_DIV)) u_fall (
        .clock  (clock),
        .clear  (w_tick_clear),
        .enable (w_tick_enable),
        .tick   (fall_tick)
    );

    // Game phase register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next phase and next values of score, best score, holdoff and flap pulse; loss beats every PLAY event.
    always_comb begin
        w_next_state      = r_state;
        w_flap_pulse_next = 1'b0;
        w_score_next      = r_score;
        w_best_next       = r_best;
        w_holdoff_next    = r_holdoff;
        case (r_state)
            IDLE: begin
                if (w_flap_rise) begin
                    w_next_state = ARM;
                end
            end
            ARM: begin
                w_score_next = '0;
                w_next_state = PLAY;
            end
            PLAY: begin
                if (lossDetect) begin
                    w_next_state   = OVER;
                    w_holdoff_next = '0;
                    if (r_score > r_best) begin
                        w_best_next = r_score;
                    end
                end else begin
                    w_flap_pulse_next = w_flap_rise;
                    if (pipe_pass && (r_score != SCORE_MAX)) begin
                        w_score_next = r_score + 1'b1;
                    end
                end
            end
            OVER: begin
                if (r_holdoff != HOLDOFF_LAST) begin
                    w_holdoff_next = r_holdoff + 1'b1;
                end
                if (w_flap_rise && (r_holdoff == HOLDOFF_LAST)) begin
                    w_next_state = ARM;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Registered outputs follow the phase being entered, so they line up with r_state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_flap_q      <= 1'b0;
            r_clr_collide <= 1'b1;
            r_flap_pulse  <= 1'b0;
            r_playing     <= 1'b0;
            r_game_over   <= 1'b0;
            r_score       <= '0;
            r_best        <= '0;
            r_holdoff     <= '0;
        end else begin
            r_flap_q      <= flap_btn;
            r_clr_collide <= (w_next_state == IDLE) || (w_next_state == ARM);
            r_flap_pulse  <= w_flap_pulse_next;
            r_playing     <= (w_next_state == PLAY);
            r_game_over   <= (w_next_state == OVER);
            r_score       <= w_score_next;
            r_best        <= w_best_next;
            r_holdoff     <= w_holdoff_next;
        end
    end

    assign clr_collide = r_clr_collide;
    assign flap_pulse  = r_flap_pulse;
    assign playing     = r_playing;
    assign game_over   = r_game_over;
    assign score       = r_score;
    assign best_score  = r_best;

endmodule
